// File: rtl/axi_csr_responder_if.sv
// ---------------------------------------------------------------------------
// axi_csr_responder_if
//   Bundles the AXI4 AW/W/B and AR/R channels between a CPU-side requester
//   and the CSR responder.
//
//   Parameters
//     ID_W    width of the AWID/BID/ARID/RID fields
//     ADDR_W  byte-address width of AWADDR/ARADDR
//
//   Modports
//     slave   responder view: address/data/ready-for-response are inputs,
//             awready/wready/B/arready/R are outputs
//     master  requester view, directions mirrored
// ---------------------------------------------------------------------------
interface axi_csr_responder_if #(
  parameter int ID_W   = 5,
  parameter int ADDR_W = 7
);
  // Write address channel
  logic [ID_W-1:0]   s_axi_awid;
  logic [ADDR_W-1:0] s_axi_awaddr;
  logic [7:0]        s_axi_awlen;
  logic [1:0]        s_axi_awburst;
  logic              s_axi_awvalid;
  logic              s_axi_awready;
  // Write data channel
  logic [31:0]       s_axi_wdata;
  logic [3:0]        s_axi_wstrb;
  logic              s_axi_wlast;
  logic              s_axi_wvalid;
  logic              s_axi_wready;
  // Write response channel
  logic [ID_W-1:0]   s_axi_bid;
  logic [1:0]        s_axi_bresp;
  logic              s_axi_bvalid;
  logic              s_axi_bready;
  // Read address channel
  logic [ID_W-1:0]   s_axi_arid;
  logic [ADDR_W-1:0] s_axi_araddr;
  logic [7:0]        s_axi_arlen;
  logic [1:0]        s_axi_arburst;
  logic              s_axi_arvalid;
  logic              s_axi_arready;
  // Read data channel
  logic [ID_W-1:0]   s_axi_rid;
  logic [31:0]       s_axi_rdata;
  logic [1:0]        s_axi_rresp;
  logic              s_axi_rlast;
  logic              s_axi_rvalid;
  logic              s_axi_rready;

  modport slave (
    input  s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awburst, s_axi_awvalid,
    input  s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    input  s_axi_bready,
    input  s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arburst, s_axi_arvalid,
    input  s_axi_rready,
    output s_axi_awready, s_axi_wready,
    output s_axi_bid, s_axi_bresp, s_axi_bvalid,
    output s_axi_arready,
    output s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
  );

  modport master (
    output s_axi_awid, s_axi_awaddr, s_axi_awlen, s_axi_awburst, s_axi_awvalid,
    output s_axi_wdata, s_axi_wstrb, s_axi_wlast, s_axi_wvalid,
    output s_axi_bready,
    output s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arburst, s_axi_arvalid,
    output s_axi_rready,
    input  s_axi_awready, s_axi_wready,
    input  s_axi_bid, s_axi_bresp, s_axi_bvalid,
    input  s_axi_arready,
    input  s_axi_rid, s_axi_rdata, s_axi_rresp, s_axi_rlast, s_axi_rvalid
  );
endinterface

// File: rtl/axi_csr_responder.sv
// ---------------------------------------------------------------------------
// axi_csr_responder
//   AXI4 responder backing a NUM_REGS x 32-bit CPU control/status register
//   file. Independent write (AW/W/B) and read (AR/R) state machines share one
//   register array. INCR and FIXED bursts are supported (burst code 10 and 11
//   behave as INCR); the register index is the word address modulo NUM_REGS.
//   One write and one read burst may be in flight at a time.
//
//   Optional feature (compile-time macro AXI_CSR_RANGE_CHECK_EN):
//     defined   - an address with any bit above the index field set flags the
//                 whole burst: writes suppressed, BRESP=SLVERR, every read
//                 beat returns 0 with RRESP=SLVERR.
//     undefined - upper address bits alias into the array, responses OKAY.
//
//   Ports
//     clk    single clock, all state on posedge
//     reset  asynchronous, active-high reset (deassert synchronously)
//     bus    axi_csr_responder_if.slave - AXI AW/W/B/AR/R channels
// ---------------------------------------------------------------------------
module axi_csr_responder #(
  parameter int ID_W     = 5,
  parameter int NUM_REGS = 32,
  parameter int ADDR_W   = 7
) (
  input  logic                 clk,
  input  logic                 reset,
  axi_csr_responder_if.slave   bus
);

  localparam int IDX_W = $clog2(NUM_REGS);

`ifdef AXI_CSR_RANGE_CHECK_EN
  localparam bit RANGE_CHECK = 1'b1;
`else
  localparam bit RANGE_CHECK = 1'b0;
`endif

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // Register index is the word address; byte-offset bits [1:0] are dropped.
  function automatic logic [IDX_W-1:0] addr_index(input logic [ADDR_W-1:0] addr);
    return addr[IDX_W+1:2];
  endfunction

  // Any address bit above the index field marks the burst as out of range.
  function automatic logic addr_error(input logic [ADDR_W-1:0] addr);
    return RANGE_CHECK && ((addr >> (IDX_W + 2)) != '0);
  endfunction

  // FIXED holds the index; everything else increments, wrapping at NUM_REGS.
  function automatic logic [IDX_W-1:0] next_index(input logic [IDX_W-1:0] idx,
                                                  input logic             fixed);
    return fixed ? idx : idx + 1'b1;
  endfunction

  function automatic logic [31:0] apply_strb(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  strb);
    logic [31:0] res;
    res = old_val;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) res[8*b +: 8] = new_val[8*b +: 8];
    end
    return res;
  endfunction

  // Register array, written only by the write FSM.
  logic [31:0] regs [NUM_REGS];

  // Write FSM state and registered outputs
  w_state_t          w_state;
  logic              aw_ready;
  logic              w_ready;
  logic              b_valid;
  logic [ID_W-1:0]   b_id;
  logic [1:0]        b_resp;
  logic [ID_W-1:0]   w_id;
  logic [IDX_W-1:0]  w_idx;
  logic [7:0]        w_len;
  logic [7:0]        w_cnt;
  logic              w_fixed;
  logic              w_err;

  // Read FSM state and registered outputs
  r_state_t          r_state;
  logic              ar_ready;
  logic              r_valid;
  logic [ID_W-1:0]   r_id;
  logic [31:0]       r_data;
  logic [1:0]        r_resp;
  logic              r_last;
  logic [IDX_W-1:0]  r_idx;
  logic [7:0]        r_len;
  logic [7:0]        r_cnt;
  logic              r_fixed;
  logic              r_err;

  // wlast is not needed: the beat counter against AWLEN ends the burst.
  logic unused_inputs;
  assign unused_inputs = ^{bus.s_axi_wlast, bus.s_axi_awaddr[1:0], bus.s_axi_araddr[1:0]};

  // -------------------------------------------------------------------------
  // Write path: W_IDLE -> W_DATA -> W_RESP
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      w_state  <= W_IDLE;
      aw_ready <= 1'b0;
      w_ready  <= 1'b0;
      b_valid  <= 1'b0;
      b_id     <= '0;
      b_resp   <= RESP_OKAY;
      w_id     <= '0;
      w_idx    <= '0;
      w_len    <= '0;
      w_cnt    <= '0;
      w_fixed  <= 1'b0;
      w_err    <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      case (w_state)
        W_IDLE: begin
          if (aw_ready && bus.s_axi_awvalid) begin
            w_id     <= bus.s_axi_awid;
            w_idx    <= addr_index(bus.s_axi_awaddr);
            w_len    <= bus.s_axi_awlen;
            w_cnt    <= '0;
            w_fixed  <= (bus.s_axi_awburst == 2'b00);
            w_err    <= addr_error(bus.s_axi_awaddr);
            aw_ready <= 1'b0;
            w_ready  <= 1'b1;
            w_state  <= W_DATA;
          end else begin
            // Also raises awready on the first edge after reset release.
            aw_ready <= 1'b1;
          end
        end

        W_DATA: begin
          if (w_ready && bus.s_axi_wvalid) begin
            if (!w_err) begin
              regs[w_idx] <= apply_strb(regs[w_idx], bus.s_axi_wdata, bus.s_axi_wstrb);
            end
            if (w_cnt == w_len) begin
              w_ready <= 1'b0;
              b_valid <= 1'b1;
              b_id    <= w_id;
              b_resp  <= w_err ? RESP_SLVERR : RESP_OKAY;
              w_state <= W_RESP;
            end else begin
              w_cnt <= w_cnt + 8'd1;
              w_idx <= next_index(w_idx, w_fixed);
            end
          end
        end

        W_RESP: begin
          if (bus.s_axi_bready) begin
            b_valid  <= 1'b0;
            aw_ready <= 1'b1;
            w_state  <= W_IDLE;
          end
        end

        default: begin
          w_state  <= W_IDLE;
          aw_ready <= 1'b0;
          w_ready  <= 1'b0;
          b_valid  <= 1'b0;
        end
      endcase
    end
  end

  // -------------------------------------------------------------------------
  // Read path: R_IDLE -> R_DATA
  // Each beat is loaded from the array on the edge that accepts the previous
  // beat (or the AR), so a write on the same edge is not yet visible to it.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= R_IDLE;
      ar_ready <= 1'b0;
      r_valid  <= 1'b0;
      r_id     <= '0;
      r_data   <= '0;
      r_resp   <= RESP_OKAY;
      r_last   <= 1'b0;
      r_idx    <= '0;
      r_len    <= '0;
      r_cnt    <= '0;
      r_fixed  <= 1'b0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        R_IDLE: begin
          if (ar_ready && bus.s_axi_arvalid) begin
            r_id     <= bus.s_axi_arid;
            r_idx    <= addr_index(bus.s_axi_araddr);
            r_len    <= bus.s_axi_arlen;
            r_cnt    <= '0;
            r_fixed  <= (bus.s_axi_arburst == 2'b00);
            r_err    <= addr_error(bus.s_axi_araddr);
            r_data   <= addr_error(bus.s_axi_araddr) ? '0
                                                     : regs[addr_index(bus.s_axi_araddr)];
            r_resp   <= addr_error(bus.s_axi_araddr) ? RESP_SLVERR : RESP_OKAY;
            r_last   <= (bus.s_axi_arlen == 8'd0);
            r_valid  <= 1'b1;
            ar_ready <= 1'b0;
            r_state  <= R_DATA;
          end else begin
            ar_ready <= 1'b1;
          end
        end

        R_DATA: begin
          // Outputs hold while the requester stalls.
          if (bus.s_axi_rready) begin
            if (r_last) begin
              r_valid  <= 1'b0;
              r_last   <= 1'b0;
              ar_ready <= 1'b1;
              r_state  <= R_IDLE;
            end else begin
              r_idx  <= next_index(r_idx, r_fixed);
              r_data <= r_err ? '0 : regs[next_index(r_idx, r_fixed)];
              r_cnt  <= r_cnt + 8'd1;
              r_last <= ((r_cnt + 8'd1) == r_len);
            end
          end
        end

        default: begin
          r_state  <= R_IDLE;
          ar_ready <= 1'b0;
          r_valid  <= 1'b0;
        end
      endcase
    end
  end

  assign bus.s_axi_awready = aw_ready;
  assign bus.s_axi_wready  = w_ready;
  assign bus.s_axi_bvalid  = b_valid;
  assign bus.s_axi_bid     = b_id;
  assign bus.s_axi_bresp   = b_resp;
  assign bus.s_axi_arready = ar_ready;
  assign bus.s_axi_rvalid  = r_valid;
  assign bus.s_axi_rid     = r_id;
  assign bus.s_axi_rdata   = r_data;
  assign bus.s_axi_rresp   = r_resp;
  assign bus.s_axi_rlast   = r_last;

endmodule

// File: tb/tb_axi_csr_responder.sv
// ---------------------------------------------------------------------------
// tb_axi_csr_responder
//   Self-checking bench for axi_csr_responder. A behavioural register-file
//   model (plain array + byte-strobe arithmetic) predicts every B and R beat.
//   Directed table vectors, hand-written multi-cycle sequences and a
//   randomized phase drive the DUT through the interface.
// ---------------------------------------------------------------------------
module tb_axi_csr_responder;
  localparam int ID_W     = 5;
  localparam int NUM_REGS = 32;
  localparam int ADDR_W   = 8;   // one bit wider than the index field + offset

`ifdef AXI_CSR_RANGE_CHECK_EN
  localparam bit RC_EN = 1'b1;
`else
  localparam bit RC_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  axi_csr_responder_if #(.ID_W(ID_W), .ADDR_W(ADDR_W)) bus ();

  axi_csr_responder #(.ID_W(ID_W), .NUM_REGS(NUM_REGS), .ADDR_W(ADDR_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  logic [31:0] model [NUM_REGS];
  logic [31:0] wd [256];
  logic [3:0]  ws [256];
  logic [31:0] last_rdata;

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] data;
    logic [3:0]  strb;
    logic [31:0] exp;
  } vec_t;
  vec_t vt [6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic bit m_err(input logic [ADDR_W-1:0] a);
    return RC_EN && (int'(a) >= NUM_REGS * 4);
  endfunction

  function automatic int m_idx(input logic [ADDR_W-1:0] a, input int beat, input logic [1:0] burst);
    return ((int'(a) / 4) + ((burst == 2'b00) ? 0 : beat)) % NUM_REGS;
  endfunction

  function automatic logic [31:0] m_strb(input logic [31:0] old_v, input logic [31:0] new_v,
                                         input logic [3:0] s);
    logic [31:0] r;
    r = old_v;
    for (int k = 0; k < 4; k++) if (s[k]) r[8*k +: 8] = new_v[8*k +: 8];
    return r;
  endfunction

  task automatic idle_inputs();
    bus.s_axi_awid = '0; bus.s_axi_awaddr = '0; bus.s_axi_awlen = '0; bus.s_axi_awburst = '0;
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = '0; bus.s_axi_wstrb = '0; bus.s_axi_wlast = 1'b0; bus.s_axi_wvalid = 1'b0;
    bus.s_axi_bready = 1'b0;
    bus.s_axi_arid = '0; bus.s_axi_araddr = '0; bus.s_axi_arlen = '0; bus.s_axi_arburst = '0;
    bus.s_axi_arvalid = 1'b0;
    bus.s_axi_rready = 1'b0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Full write burst using wd[]/ws[]; bstall = cycles bready is held low.
  task automatic do_write(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                          input int len, input logic [1:0] burst, input int bstall,
                          input bit gaps);
    int n;
    bit err;
    bus.s_axi_awid = id; bus.s_axi_awaddr = addr; bus.s_axi_awlen = 8'(len);
    bus.s_axi_awburst = burst; bus.s_axi_awvalid = 1'b1;
    n = 0;
    while (!bus.s_axi_awready && n < 50) begin step(); n++; end
    if (n >= 50) chk("aw_timeout", 32'd1, 32'd0);
    step();
    bus.s_axi_awvalid = 1'b0;
    for (int b = 0; b <= len; b++) begin
      if (gaps) begin
        bus.s_axi_wvalid = 1'b0;
        repeat ($urandom_range(0, 2)) step();
      end
      bus.s_axi_wdata = wd[b]; bus.s_axi_wstrb = ws[b];
      bus.s_axi_wlast = (b == len); bus.s_axi_wvalid = 1'b1;
      n = 0;
      while (!bus.s_axi_wready && n < 50) begin step(); n++; end
      if (n >= 50) begin chk("w_timeout", 32'd1, 32'd0); break; end
      step();
    end
    bus.s_axi_wvalid = 1'b0; bus.s_axi_wlast = 1'b0;
    err = m_err(addr);
    chk("bvalid", 32'(bus.s_axi_bvalid), 32'd1);
    chk("bid", 32'(bus.s_axi_bid), 32'(id));
    chk("bresp", 32'(bus.s_axi_bresp), err ? 32'd2 : 32'd0);
    chk("awready_in_resp", 32'(bus.s_axi_awready), 32'd0);
    for (int s = 0; s < bstall; s++) begin
      step();
      chk("bvalid_stall", 32'(bus.s_axi_bvalid), 32'd1);
      chk("bid_stall", 32'(bus.s_axi_bid), 32'(id));
      chk("awready_stall", 32'(bus.s_axi_awready), 32'd0);
    end
    bus.s_axi_bready = 1'b1;
    step();
    bus.s_axi_bready = 1'b0;
    chk("bvalid_after", 32'(bus.s_axi_bvalid), 32'd0);
    chk("awready_after", 32'(bus.s_axi_awready), 32'd1);
    if (!err) begin
      for (int b = 0; b <= len; b++) begin
        model[m_idx(addr, b, burst)] = m_strb(model[m_idx(addr, b, burst)], wd[b], ws[b]);
      end
    end
  endtask

  // Full read burst. mode 0: rready high, 1: toggle 1,0,1,0.., 2: random.
  task automatic do_read(input logic [ID_W-1:0] id, input logic [ADDR_W-1:0] addr,
                         input int len, input logic [1:0] burst, input int mode);
    int n, b, c;
    bit rr, err;
    bus.s_axi_arid = id; bus.s_axi_araddr = addr; bus.s_axi_arlen = 8'(len);
    bus.s_axi_arburst = burst; bus.s_axi_arvalid = 1'b1;
    n = 0;
    while (!bus.s_axi_arready && n < 50) begin step(); n++; end
    if (n >= 50) chk("ar_timeout", 32'd1, 32'd0);
    step();
    bus.s_axi_arvalid = 1'b0;
    err = m_err(addr);
    b = 0; c = 0;
    while (b <= len && c < 200) begin
      rr = (mode == 0) ? 1'b1 : (mode == 1) ? ((c % 2) == 0) : 1'($urandom_range(0, 1));
      bus.s_axi_rready = rr;
      chk("rvalid", 32'(bus.s_axi_rvalid), 32'd1);
      if (!bus.s_axi_rvalid) break;
      chk("rdata", bus.s_axi_rdata, err ? 32'd0 : model[m_idx(addr, b, burst)]);
      chk("rid", 32'(bus.s_axi_rid), 32'(id));
      chk("rresp", 32'(bus.s_axi_rresp), err ? 32'd2 : 32'd0);
      chk("rlast", 32'(bus.s_axi_rlast), (b == len) ? 32'd1 : 32'd0);
      last_rdata = bus.s_axi_rdata;
      step();
      if (rr) b++;
      c++;
    end
    bus.s_axi_rready = 1'b0;
    if (c >= 200) chk("r_timeout", 32'd1, 32'd0);
    chk("rvalid_end", 32'(bus.s_axi_rvalid), 32'd0);
    chk("arready_end", 32'(bus.s_axi_arready), 32'd1);
  endtask

  task automatic chk_outputs_zero(input string tag);
    chk({tag, "_awready"}, 32'(bus.s_axi_awready), 32'd0);
    chk({tag, "_wready"},  32'(bus.s_axi_wready),  32'd0);
    chk({tag, "_bvalid"},  32'(bus.s_axi_bvalid),  32'd0);
    chk({tag, "_bid"},     32'(bus.s_axi_bid),     32'd0);
    chk({tag, "_bresp"},   32'(bus.s_axi_bresp),   32'd0);
    chk({tag, "_arready"}, 32'(bus.s_axi_arready), 32'd0);
    chk({tag, "_rvalid"},  32'(bus.s_axi_rvalid),  32'd0);
    chk({tag, "_rid"},     32'(bus.s_axi_rid),     32'd0);
    chk({tag, "_rdata"},   bus.s_axi_rdata,        32'd0);
    chk({tag, "_rresp"},   32'(bus.s_axi_rresp),   32'd0);
    chk({tag, "_rlast"},   32'(bus.s_axi_rlast),   32'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] old5, reg0_before;
    vt[0] = '{8'h08, 32'hDEADBEEF, 4'b1111, 32'hDEADBEEF};
    vt[1] = '{8'h0C, 32'hFFFFFFFF, 4'b1111, 32'hFFFFFFFF};
    vt[2] = '{8'h0C, 32'h12345678, 4'b0101, 32'hFF34FF78};
    vt[3] = '{8'h0D, 32'hAABBCCDD, 4'b1000, 32'hAA34FF78};
    vt[4] = '{8'h7C, 32'h0F0F0F0F, 4'b0011, 32'h00000F0F};
    vt[5] = '{8'h7E, 32'h11223344, 4'b0100, 32'h00220F0F};
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;

    // Reset state and release
    idle_inputs();
    reset = 1'b1;
    repeat (3) step();
    chk_outputs_zero("reset");
    reset = 1'b0;
    chk("awready_before_edge", 32'(bus.s_axi_awready), 32'd0);
    step();
    chk("awready_after_reset", 32'(bus.s_axi_awready), 32'd1);
    chk("arready_after_reset", 32'(bus.s_axi_arready), 32'd1);

    // Directed single-beat table
    for (int i = 0; i < 6; i++) begin
      wd[0] = vt[i].data; ws[0] = vt[i].strb;
      do_write(5'(i + 1), vt[i].addr, 0, 2'b01, 0, 1'b0);
      do_read(5'(i + 10), vt[i].addr, 0, 2'b01, 0);
      chk("table_read", last_rdata, vt[i].exp);
    end

    // INCR write wrapping past the top register, read back with rready toggling
    for (int b = 0; b < 4; b++) begin wd[b] = 32'(b + 1); ws[b] = 4'hF; end
    do_write(5'd7, 8'h78, 3, 2'b01, 0, 1'b0);
    do_read(5'd8, 8'h78, 3, 2'b01, 1);
    chk("incr_wrap_last", last_rdata, 32'd4);
    do_read(5'd9, 8'h00, 0, 2'b01, 0);
    chk("incr_wrap_reg0", last_rdata, 32'd3);

    // Response stalled by bready low for 5 cycles
    wd[0] = 32'h5A5A0001; ws[0] = 4'hF;
    do_write(5'd17, 8'h40, 0, 2'b10, 5, 1'b0);

    // FIXED read of reg 5 while a write to reg 5 lands mid-burst
    wd[0] = 32'h11111111; ws[0] = 4'hF;
    do_write(5'd2, 8'h14, 0, 2'b01, 0, 1'b0);
    old5 = model[5];
    bus.s_axi_arid = 5'd21; bus.s_axi_araddr = 8'h14; bus.s_axi_arlen = 8'd2;
    bus.s_axi_arburst = 2'b00; bus.s_axi_arvalid = 1'b1;
    bus.s_axi_awid = 5'd22; bus.s_axi_awaddr = 8'h14; bus.s_axi_awlen = 8'd0;
    bus.s_axi_awburst = 2'b01; bus.s_axi_awvalid = 1'b1;
    step();                                   // AR and AW accepted
    bus.s_axi_arvalid = 1'b0; bus.s_axi_awvalid = 1'b0;
    chk("coll_beat0", bus.s_axi_rdata, old5);
    bus.s_axi_wdata = 32'hA5A5A5A5; bus.s_axi_wstrb = 4'hF;
    bus.s_axi_wlast = 1'b1; bus.s_axi_wvalid = 1'b1; bus.s_axi_rready = 1'b1;
    step();                                   // write edge, beat 1 loaded here
    bus.s_axi_wvalid = 1'b0; bus.s_axi_wlast = 1'b0; bus.s_axi_bready = 1'b1;
    chk("coll_beat1_old", bus.s_axi_rdata, old5);
    chk("coll_beat1_rlast", 32'(bus.s_axi_rlast), 32'd0);
    chk("coll_bvalid", 32'(bus.s_axi_bvalid), 32'd1);
    step();
    bus.s_axi_bready = 1'b0;
    chk("coll_beat2_new", bus.s_axi_rdata, 32'hA5A5A5A5);
    chk("coll_beat2_rlast", 32'(bus.s_axi_rlast), 32'd1);
    step();
    bus.s_axi_rready = 1'b0;
    chk("coll_rvalid_end", 32'(bus.s_axi_rvalid), 32'd0);
    model[5] = 32'hA5A5A5A5;

    // Out-of-range address (SLVERR with range checking, alias to reg 0 without)
    reg0_before = model[0];
    wd[0] = 32'h00000001; ws[0] = 4'hF;
    do_write(5'd30, 8'h80, 0, 2'b01, 0, 1'b0);
    do_read(5'd31, 8'h80, 0, 2'b01, 0);
    chk("range_read", last_rdata, RC_EN ? 32'd0 : 32'd1);
    do_read(5'd29, 8'h00, 0, 2'b01, 0);
    chk("range_reg0", last_rdata, RC_EN ? reg0_before : 32'd1);

    // Reset in the middle of a write burst
    wd[0] = 32'hCAFEF00D; ws[0] = 4'hF;
    bus.s_axi_awid = 5'd3; bus.s_axi_awaddr = 8'h20; bus.s_axi_awlen = 8'd3;
    bus.s_axi_awburst = 2'b01; bus.s_axi_awvalid = 1'b1;
    step();
    bus.s_axi_awvalid = 1'b0;
    bus.s_axi_wdata = 32'hCAFEF00D; bus.s_axi_wstrb = 4'hF; bus.s_axi_wvalid = 1'b1;
    step();
    bus.s_axi_wvalid = 1'b0;
    #2 reset = 1'b1;
    #1 chk_outputs_zero("midreset");
    step();
    reset = 1'b0;
    for (int i = 0; i < NUM_REGS; i++) model[i] = '0;
    step();
    chk("awready_after_midreset", 32'(bus.s_axi_awready), 32'd1);
    chk("bvalid_after_midreset", 32'(bus.s_axi_bvalid), 32'd0);
    do_read(5'd4, 8'h20, 0, 2'b01, 0);
    chk("midreset_reg8", last_rdata, 32'd0);
    do_read(5'd5, 8'h08, 0, 2'b01, 0);
    chk("midreset_reg2", last_rdata, 32'd0);

    // Randomized traffic against the model
    for (int t = 0; t < 60; t++) begin
      int len;
      logic [1:0] burst;
      logic [ADDR_W-1:0] addr;
      len   = $urandom_range(0, 7);
      burst = 2'($urandom_range(0, 2));
      addr  = 8'($urandom_range(0, 255));
      if ($urandom_range(0, 1) == 1) begin
        for (int b = 0; b <= len; b++) begin
          wd[b] = $urandom;
          ws[b] = 4'($urandom_range(0, 15));
        end
        do_write(5'($urandom_range(0, 31)), addr, len, burst,
                 $urandom_range(0, 2), 1'($urandom_range(0, 1)));
      end else begin
        do_read(5'($urandom_range(0, 31)), addr, len, burst, 2);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_csr_responder.md
Name: axi_csr_responder

Overview:
- AXI4 slave (responder) backing a 32 x 32-bit CPU control/status register file.
- It is the far end of the simplified read/write wrapper used by the CPU core. It accepts AW/W/B and AR/R channel traffic, including INCR/FIXED bursts, and stores the register contents.
- Write and read paths are independent state machines sharing one register array.

Parameters:
- ID_W, 5, width of AWID/BID/ARID/RID.
- NUM_REGS, 32, register count (power of 2; the index is the low log2(NUM_REGS) bits of the word address).
- ADDR_W, 7, byte-address width; register index = addr[6:2] at default values.

Ports:
- clk  in  1  single clock; all logic on posedge.
- reset  in  1  asynchronous, active-high reset.
- s_axi_awid  in  ID_W  write ID
- s_axi_awaddr  in  ADDR_W  write byte address
- s_axi_awlen  in  8  beats-1
- s_axi_awburst  in  2  00 FIXED, 01 INCR, 10 treated as INCR
- s_axi_awvalid / s_axi_awready  in / out  1  AW handshake
- s_axi_wdata  in  32  write data
- s_axi_wstrb  in  4  byte enables
- s_axi_wlast  in  1  last write beat
- s_axi_wvalid / s_axi_wready  in / out  1  W handshake
- s_axi_bid  out  ID_W  echoed AWID
- s_axi_bresp  out  2  write response
- s_axi_bvalid / s_axi_bready  out / in  1  B handshake
- s_axi_arid, s_axi_araddr, s_axi_arlen, s_axi_arburst  in  ID_W / ADDR_W / 8 / 2  read address channel
- s_axi_arvalid / s_axi_arready  in / out  1  AR handshake
- s_axi_rid  out  ID_W  echoed ARID
- s_axi_rdata  out  32  read data
- s_axi_rresp  out  2  read response
- s_axi_rlast  out  1  last read beat
- s_axi_rvalid / s_axi_rready  out / in  1  R handshake

Behaviour:
- Reset (async assert, sync deassert):
  - All registers cleared to 0; both FSMs return to IDLE.
  - All ready/valid outputs are 0; bid/rid/rdata/bresp/rresp/rlast are 0.
  - awready and arready go to 1 on the first clock edge after deassert.
  - Reset mid-transaction abandons it; no B or R beat is issued.
- Write FSM, W_IDLE -> W_DATA -> W_RESP:
  - W_IDLE: awready=1. On the AW handshake, latch id, index, len and burst; go to W_DATA. awready is 0 outside W_IDLE.
  - W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb into reg[index]; bytes with strobe 0 are unchanged.
  - After each beat, the index increments mod NUM_REGS for INCR and holds for FIXED.
  - The beat counter reaching len ends the burst and moves to W_RESP. wlast is not used for termination.
  - W_RESP: bvalid=1, bid=latched id, bresp=OKAY (00). bvalid is held until bready. On handshake, return to W_IDLE.
  - Exactly one outstanding write; throughput is len+3 cycles per burst with continuous valid/ready.
- Read FSM, R_IDLE -> R_DATA:
  - R_IDLE: arready=1. The AR handshake at edge N loads rdata=reg[index], rid, and rlast=(len==0). rvalid=1 from edge N+1, i.e. one cycle of latency.
  - R_DATA: outputs are held stable while rvalid && !rready.
  - On an R handshake that is not last: advance the index (INCR/FIXED rule as for writes) and load the next beat on the same edge. There are no bubbles.
  - On the last handshake: rvalid=0, return to R_IDLE. rresp=OKAY.
  - Index wrap: INCR past NUM_REGS-1 wraps to 0.
- Read/write collision on the same register in the same cycle: the read samples the old value; the write is visible to reads loaded from the next edge on.
- Address bits [1:0] are ignored.

Optional Feature:
- Macro AXI_CSR_RANGE_CHECK_EN.
- Defined:
  - An AW or AR address with any bit above the index field set (addr >= NUM_REGS*4) marks the whole burst as an error.
  - Writes are suppressed for all beats, and bresp=SLVERR (10).
  - Every read beat returns rdata=0 and rresp=SLVERR.
- Undefined: upper address bits are ignored, the address aliases into the array, and responses are always OKAY.

Test Plan:
- Reset, then AW addr 0x08 len 0 plus W 0xDEADBEEF strb 1111 -> bvalid one cycle after the W beat with bresp 00 and bid equal to awid; AR 0x08 -> rdata 0xDEADBEEF, rlast=1, rid echoed.
- Write 0xFFFFFFFF to reg 3, then write 0x12345678 with strb 0101 -> reg 3 reads back 0xFF34FF78.
- INCR write len 3 at addr 0x78 with data 1,2,3,4 -> regs 30,31,0,1 = 1,2,3,4. INCR read len 3 at 0x78 with rready toggling 1,0,1,0 -> the same four beats in order, data stable while stalled, rlast only on the 4th beat.
- FIXED read len 2 at reg 5 while a write of 0xA5A5A5A5 to reg 5 completes mid-burst -> beats already loaded return the old value; beats loaded after the write edge return 0xA5A5A5A5.
- Hold bready=0 for 5 cycles -> bvalid and bid stay stable and awready stays 0. Assert reset during W_DATA -> all outputs 0, registers read back 0 after reset.
- With AXI_CSR_RANGE_CHECK_EN defined, AW 0x80 plus W 0x1 -> bresp 10 and reg 0 unchanged; AR 0x80 -> rresp 10, rdata 0. Without the macro, the same write returns bresp 00 and reg 0 = 0x1.
